// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle-latency ROM, and hands
// (inst, pc) pairs to decode over valid/ready. A 1-entry skid holds a word decode refused.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_pc_o,
    input  logic [31:0] rom_inst_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        id_ready_i,
    output logic        id_valid_o,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o
);

    logic [31:0] pc_q, pc_d;
    logic        req_vld_q, req_vld_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        skid_vld_q, skid_vld_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic [31:0] jump_target;
    logic        out_vld;
    logic        issue;
    logic        capture;
    logic        drain;
    logic [1:0]  unused_jump_lsbs;

    assign unused_jump_lsbs = jump_addr_i[1:0];
    assign jump_target      = {jump_addr_i[31:2], 2'b00};

    // A redirect kills whatever is presented this cycle, including a held skid word.
    assign out_vld = (skid_vld_q | req_vld_q) & ~jump_en_i;
    assign issue   = ~jump_en_i & (id_ready_i | (~skid_vld_q & ~req_vld_q));
    assign capture = req_vld_q & ~skid_vld_q & ~id_ready_i & ~jump_en_i;
    assign drain   = out_vld & id_ready_i & skid_vld_q;

    always_comb begin
        pc_d        = pc_q;
        req_vld_d   = req_vld_q;
        req_pc_d    = req_pc_q;
        skid_vld_d  = skid_vld_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;

        if (jump_en_i) begin
            pc_d       = jump_target;
            req_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            if (issue) begin
                req_vld_d = 1'b1;
                req_pc_d  = pc_q;
                pc_d      = pc_q + 32'd4;
            end else begin
                // Stalled: PC is held so the ROM simply re-reads the same address.
                req_vld_d = 1'b0;
            end

            if (capture) begin
                skid_vld_d  = 1'b1;
                skid_inst_d = rom_inst_i;
                skid_pc_d   = req_pc_q;
            end else if (drain) begin
                skid_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_vld_q   <= 1'b0;
            req_pc_q    <= RESET_PC;
            skid_vld_q  <= 1'b0;
            skid_inst_q <= 32'h0;
            skid_pc_q   <= 32'h0;
        end else begin
            pc_q        <= pc_d;
            req_vld_q   <= req_vld_d;
            req_pc_q    <= req_pc_d;
            skid_vld_q  <= skid_vld_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign rom_pc_o   = pc_q;
    assign id_valid_o = out_vld;
    assign id_pc_o    = skid_vld_q ? skid_pc_q : req_pc_q;

    always_comb begin
        id_inst_o = NOP_INST;
        if (out_vld) begin
            id_inst_o = skid_vld_q ? skid_inst_q : rom_inst_i;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: ROM model returns byte_addr/4, one line per accepted word.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rom_pc_o;
    logic [31:0] rom_inst_i;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        id_ready_i = 1'b1;
    logic        id_valid_o;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;

    logic [31:0] rom_q = 32'h0;
    logic [31:0] acc_pc[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom_pc_o >> 2;
    assign rom_inst_i = rom_q;

    if_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .rom_pc_o   (rom_pc_o),
        .rom_inst_i (rom_inst_i),
        .jump_en_i  (jump_en_i),
        .jump_addr_i(jump_addr_i),
        .id_ready_i (id_ready_i),
        .id_valid_o (id_valid_o),
        .id_inst_o  (id_inst_o),
        .id_pc_o    (id_pc_o)
    );

    // Check the skid/request invariant, log an accepted word, then move past the next edge.
    task automatic adv();
        checks++;
        if (!rst && dut.skid_vld_q && dut.req_vld_q) begin
            errors++;
            $display("FAIL invariant: skid_vld=1 req_vld=1, required req_vld=0 while skid holds");
        end
        if (id_valid_o && id_ready_i) begin
            acc_pc.push_back(id_pc_o);
            $display("t=%0t accept pc=%h inst=%h", $time, id_pc_o, id_inst_o);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; id_ready_i = 1'b1; jump_en_i = 1'b0;
        @(posedge clk); #2;
        checks++; if (rom_pc_o !== 32'h0) begin errors++; $display("FAIL reset_rom_pc: got %h required %h", rom_pc_o, 32'h0); end
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", id_valid_o); end
        checks++; if (id_inst_o !== NOP) begin errors++; $display("FAIL reset_inst: got %h required %h", id_inst_o, NOP); end
        checks++; if (id_pc_o !== 32'h0) begin errors++; $display("FAIL reset_id_pc: got %h required %h", id_pc_o, 32'h0); end
        rst = 1'b0;
        #1;
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL release_valid: got %b required 0", id_valid_o); end
        adv();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b required 1", i, id_valid_o); end
            checks++; if (id_pc_o !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h required %h", i, id_pc_o, 32'(4 * i)); end
            checks++; if (id_inst_o !== 32'(i)) begin errors++; $display("FAIL stream_inst[%0d]: got %h required %h", i, id_inst_o, 32'(i)); end
            adv();
        end
    endtask

    task automatic test_stall();
        id_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b required 1", i, id_valid_o); end
            checks++; if (id_pc_o !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d]: got %h required 8", i, id_pc_o); end
            checks++; if (id_inst_o !== 32'h2) begin errors++; $display("FAIL stall_inst[%0d]: got %h required 2", i, id_inst_o); end
            checks++; if (rom_pc_o !== 32'hC) begin errors++; $display("FAIL stall_rom_pc[%0d]: got %h required c", i, rom_pc_o); end
            adv();
        end
        id_ready_i = 1'b1;
        #1;
        checks++; if (id_pc_o !== 32'h8 || id_inst_o !== 32'h2) begin errors++; $display("FAIL release_first: got pc %h inst %h required pc 8 inst 2", id_pc_o, id_inst_o); end
        adv();
        #1;
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'hC || id_inst_o !== 32'h3) begin errors++; $display("FAIL release_next: got v%b pc %h inst %h required v1 pc c inst 3", id_valid_o, id_pc_o, id_inst_o); end
        adv();
    endtask

    task automatic test_jump();
        #1;
        checks++; if (id_pc_o !== 32'h10) begin errors++; $display("FAIL jump_pre_pc: got %h required 10", id_pc_o); end
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0043;
        #1;
        checks++; if (id_valid_o !== 1'b0 || id_inst_o !== NOP) begin errors++; $display("FAIL jump_suppress: got v%b inst %h required v0 inst %h", id_valid_o, id_inst_o, NOP); end
        adv();
        jump_en_i = 1'b0;
        #1;
        checks++; if (rom_pc_o !== 32'h40) begin errors++; $display("FAIL jump_rom_pc: got %h required 40", rom_pc_o); end
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL jump_bubble: got %b required 0", id_valid_o); end
        adv();
        #1;
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h40 || id_inst_o !== 32'h10) begin errors++; $display("FAIL jump_target: got v%b pc %h inst %h required v1 pc 40 inst 10", id_valid_o, id_pc_o, id_inst_o); end
        adv();
        #1;
        checks++; if (id_pc_o !== 32'h44 || id_inst_o !== 32'h11) begin errors++; $display("FAIL jump_next: got pc %h inst %h required pc 44 inst 11", id_pc_o, id_inst_o); end
        adv();
        checks++;
        if (acc_pc.size() != 6 || acc_pc[0] !== 32'h0 || acc_pc[1] !== 32'h4 || acc_pc[2] !== 32'h8 ||
            acc_pc[3] !== 32'hC || acc_pc[4] !== 32'h40 || acc_pc[5] !== 32'h44) begin
            errors++;
            $display("FAIL accepted_seq: got %0d entries %p required 0,4,8,c,40,44", acc_pc.size(), acc_pc);
        end
    endtask

    task automatic test_jump_during_stall();
        jump_en_i = 1'b1; jump_addr_i = 32'h20;
        #1; adv();
        jump_en_i = 1'b0;
        #1; adv();
        id_ready_i = 1'b0;
        #1;
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h20) begin errors++; $display("FAIL js_present: got v%b pc %h required v1 pc 20", id_valid_o, id_pc_o); end
        adv();
        #1;
        checks++; if (id_pc_o !== 32'h20 || id_inst_o !== 32'h8) begin errors++; $display("FAIL js_skid: got pc %h inst %h required pc 20 inst 8", id_pc_o, id_inst_o); end
        acc_pc.delete();
        jump_en_i = 1'b1; jump_addr_i = 32'h100; id_ready_i = 1'b1;
        #1;
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL js_suppress: got %b required 0", id_valid_o); end
        adv();
        jump_en_i = 1'b0;
        #1;
        checks++; if (id_valid_o !== 1'b0 || rom_pc_o !== 32'h100) begin errors++; $display("FAIL js_redirect: got v%b rom_pc %h required v0 rom_pc 100", id_valid_o, rom_pc_o); end
        adv();
        #1; adv();
        checks++; if (acc_pc.size() != 1 || acc_pc[0] !== 32'h100) begin errors++; $display("FAIL js_first_accept: got %0d entries %p required 100", acc_pc.size(), acc_pc); end
    endtask

    task automatic test_back_to_back();
        jump_en_i = 1'b1; jump_addr_i = 32'h200;
        #1; adv();
        jump_addr_i = 32'h301;
        #1;
        checks++; if (id_valid_o !== 1'b0 || rom_pc_o !== 32'h200) begin errors++; $display("FAIL b2b_first: got v%b rom_pc %h required v0 rom_pc 200", id_valid_o, rom_pc_o); end
        adv();
        jump_en_i = 1'b0;
        #1;
        checks++; if (rom_pc_o !== 32'h300) begin errors++; $display("FAIL b2b_rom_pc: got %h required 300", rom_pc_o); end
        adv();
        #1;
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h300 || id_inst_o !== 32'hC0) begin errors++; $display("FAIL b2b_target: got v%b pc %h inst %h required v1 pc 300 inst c0", id_valid_o, id_pc_o, id_inst_o); end
        adv();
    endtask

    task automatic test_wrap();
        acc_pc.delete();
        jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFF8;
        #1; adv();
        jump_en_i = 1'b0;
        #1; adv();
        #1;
        checks++; if (id_inst_o !== 32'h3FFF_FFFE) begin errors++; $display("FAIL wrap_inst: got %h required 3ffffffe", id_inst_o); end
        checks++; if (rom_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_rom_pc: got %h required fffffffc", rom_pc_o); end
        adv();
        #1;
        checks++; if (rom_pc_o !== 32'h0) begin errors++; $display("FAIL wrap_rom_pc0: got %h required 0", rom_pc_o); end
        adv();
        #1; adv();
        checks++;
        if (acc_pc.size() != 3 || acc_pc[0] !== 32'hFFFF_FFF8 || acc_pc[1] !== 32'hFFFF_FFFC || acc_pc[2] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_seq: got %0d entries %p required fffffff8,fffffffc,0", acc_pc.size(), acc_pc);
        end
    endtask

    task automatic test_async_reset();
        id_ready_i = 1'b0;
        #1; adv();
        #1;
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h4) begin errors++; $display("FAIL ar_skid: got v%b pc %h required v1 pc 4", id_valid_o, id_pc_o); end
        #1; rst = 1'b1;
        #1;
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b required 0", id_valid_o); end
        checks++; if (rom_pc_o !== 32'h0) begin errors++; $display("FAIL ar_rom_pc: got %h required 0", rom_pc_o); end
        checks++; if (id_pc_o !== 32'h0 || id_inst_o !== NOP) begin errors++; $display("FAIL ar_out: got pc %h inst %h required pc 0 inst %h", id_pc_o, id_inst_o, NOP); end
        adv(); adv();
        rst = 1'b0; id_ready_i = 1'b1;
        #1;
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL ar_release: got %b required 0", id_valid_o); end
        adv();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'(4 * i) || id_inst_o !== 32'(i)) begin errors++; $display("FAIL ar_restart[%0d]: got v%b pc %h inst %h required v1 pc %h inst %h", i, id_valid_o, id_pc_o, id_inst_o, 32'(4 * i), 32'(i)); end
            adv();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_jump();
        test_jump_during_stall();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage. Owns the program counter, drives the byte address into the 1-cycle-latency instruction ROM, pairs each returned word with its PC, and hands (inst, pc) to the decode stage over a valid/ready handshake. A 1-entry skid buffer holds a returned word that decode cannot take. Redirects from execute kill in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned.
- NOP_INST, 32'h0000_0013, word driven on id_inst_o whenever id_valid_o=0.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_pc_o  out  32  byte address to ROM. The ROM samples it at posedge and returns the word on rom_inst_i the following cycle.
- rom_inst_i  in  32  word for the address presented one cycle earlier.
- jump_en_i  in  1  redirect request from execute.
- jump_addr_i  in  32  redirect target. Bits [1:0] are ignored and treated as 0.
- id_ready_i  in  1  decode accepts this cycle.
- id_valid_o  out  1  id_inst_o/id_pc_o valid.
- id_inst_o  out  32  instruction to decode.
- id_pc_o  out  32  PC of id_inst_o.

## Operation
State registers:
- pc_q: next fetch address. rom_pc_o = pc_q.
- req_vld_q, req_pc_q: a fetch is in flight and its word is on rom_inst_i this cycle.
- skid_vld_q, skid_inst_q, skid_pc_q: held word.

Output mux (combinational):
- id_valid_o = (skid_vld_q | req_vld_q) & ~jump_en_i.
- If skid_vld_q: id_inst_o = skid_inst_q, id_pc_o = skid_pc_q.
- Else: id_inst_o = rom_inst_i, id_pc_o = req_pc_q.
- When id_valid_o=0, id_inst_o = NOP_INST. id_pc_o still follows the mux.

Issue rule: issue = ~jump_en_i & (id_ready_i | (~skid_vld_q & ~req_vld_q)).
- On issue: req_vld_q<=1, req_pc_q<=pc_q, pc_q<=pc_q+4 (32-bit modulo, 32'hFFFF_FFFC+4 wraps to 0).
- No issue and no jump: pc_q is held (ROM re-reads the same address), and req_vld_q<=0.

Skid capture:
- Condition: req_vld_q & ~skid_vld_q & ~id_ready_i & ~jump_en_i.
- Effect: skid_vld_q<=1, skid_inst_q<=rom_inst_i, skid_pc_q<=req_pc_q.
- Drain: id_valid_o & id_ready_i while skid_vld_q clears skid_vld_q.
- Invariant: skid_vld_q=1 implies req_vld_q=0. The bench asserts this every cycle.

Redirect (jump_en_i=1) has top priority:
- pc_q<={jump_addr_i[31:2],2'b00}, req_vld_q<=0, skid_vld_q<=0.
- The presented word is suppressed (id_valid_o=0), even if id_ready_i=1.
- Back-to-back jumps: the last one wins.

Reset (async, any time, including mid-stall or mid-redirect):
- pc_q=RESET_PC, req_pc_q=RESET_PC, req_vld_q=0, skid_vld_q=0, skid_inst_q=0, skid_pc_q=0.
- Outputs during and right after reset: rom_pc_o=RESET_PC, id_valid_o=0, id_inst_o=NOP_INST, id_pc_o=RESET_PC.

## Timing
- Reset release at edge E0: issue at E1 (RESET_PC). First id_valid_o=1 with pc RESET_PC in the cycle after E1.
- Steady state with id_ready_i=1: one instruction per cycle. PCs are consecutive +4, with no bubbles.
- Stall (id_ready_i=0): the pending word is captured into the skid. Output is stable (same inst/pc) for every stalled cycle.
- Stall release: the skid word is accepted that cycle and a new fetch issues the same cycle, so the next word follows with no bubble.
- Jump asserted in cycle N: the target is on rom_pc_o in N+1 and valid on id_* in N+2. Penalty is 2 cycles.
- Comb paths: jump_en_i→id_valid_o, rom_inst_i→id_inst_o. id_ready_i does not feed rom_pc_o (registered).

## Test plan
- Reset/stream: RESET_PC=0, ROM word at byte k = k/4. Release reset with ready=1. Required: id_pc_o 0,4,8,C… on consecutive cycles, id_inst_o 0,1,2,3, first valid one cycle after the first issue edge.
- Stall: ready=0 for 3 cycles while pc 8 is presented. Required: inst 2/pc 8 held for all 3 cycles, rom_pc_o frozen at C. On release: 8 then C on back-to-back cycles, no duplicate, no drop.
- Jump: jump_en_i=1, jump_addr_i=32'h0000_0043 while pc 10 is presented. Required: pc 10 is never accepted. rom_pc_o=40 next cycle, id_pc_o=40 two cycles after the jump, then 44.
- Jump during stall: skid full with pc 20, jump to 100. Required: the skid word is discarded, the next valid pc is 100.
- Wrap: jump to FFFF_FFF8. Required: accepted pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Async reset mid-stall: assert rst between edges with the skid full. Required: id_valid_o=0 and rom_pc_o=RESET_PC immediately, and the stream restarts from RESET_PC after release.
